// File: rtl/ramz_pkg.sv
// ramz_pkg: shared types for the ramz read-side drain.
// Widths, FSM encoding and byte-lane index.
package ramz_pkg;
  localparam int RAMZ_ADDR_W = 5;
  localparam int RAMZ_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    LOAD,
    SEND,
    DONE
  } state_t;

  typedef logic [1:0] lane_t;
endpackage

// File: rtl/ramz_word_ser.sv
// ramz_word_ser: 32->8 serializer with one-word holding register.
// A word loads straight into the shifter when it is free, else into hold.
module ramz_word_ser
  import ramz_pkg::*;
#(
  parameter int DATA_W    = RAMZ_DATA_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [DATA_W-1:0] ld_word,
  input  logic              ld_last,
  output logic              take,
  output logic              end_run,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] sh_nxt;
  logic              sh_last;
  logic              hold_vld;
  logic              hold_last;
  lane_t             lane;
  logic              fire;
  logic              wend;
  logic              free;

  assign fire    = m_valid & m_ready;
  assign wend    = fire & (lane == 2'd3);
  assign free    = !m_valid | wend;
  assign take    = free & (hold_vld | ld);
  assign end_run = wend & sh_last;
  assign m_data  = LSB_FIRST ? sh[7:0] : sh[DATA_W-1 -: 8];
  assign m_last  = m_valid & sh_last & (lane == 2'd3);
  assign sh_nxt  = LSB_FIRST ? {8'h00, sh[DATA_W-1:8]}
                             : {sh[DATA_W-9:0], 8'h00};

  // shifter reload from hold (or bypass), byte shifting and hold capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sh        <= '0;
      sh_last   <= 1'b0;
      hold      <= '0;
      hold_vld  <= 1'b0;
      hold_last <= 1'b0;
      lane      <= '0;
      m_valid   <= 1'b0;
    end else if (free) begin
      if (hold_vld) begin
        sh       <= hold;
        sh_last  <= hold_last;
        lane     <= '0;
        m_valid  <= 1'b1;
        hold_vld <= ld;
        if (ld) begin
          hold      <= ld_word;
          hold_last <= ld_last;
        end
      end else if (ld) begin
        sh      <= ld_word;
        sh_last <= ld_last;
        lane    <= '0;
        m_valid <= 1'b1;
      end else begin
        sh      <= '0;
        sh_last <= 1'b0;
        m_valid <= 1'b0;
      end
    end else begin
      if (fire) begin
        sh   <= sh_nxt;
        lane <= lane + 2'd1;
      end
      if (ld) begin
        hold      <= ld_word;
        hold_last <= ld_last;
        hold_vld  <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/ramz_drain.sv
// ramz_drain: reads a run of RAM words and streams them as bytes.
// Option RAMZ_DRAIN_CKSUM_EN adds an 8-bit running byte sum output.
module ramz_drain
  import ramz_pkg::*;
#(
  parameter int ADDR_W    = RAMZ_ADDR_W,
  parameter int DATA_W    = RAMZ_DATA_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef RAMZ_DRAIN_CKSUM_EN
  ,
  output logic [7:0]        cksum
`endif
);
  state_t          st;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] fcnt;
  logic            rq0;
  logic            rq1;
  logic            rl0;
  logic            rl1;
  logic            take;
  logic            end_run;
  logic            more;

  assign more = fcnt < len_q;

  ramz_word_ser #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .ld     (rq1),
    .ld_word(ram_dout),
    .ld_last(rl1),
    .take   (take),
    .end_run(end_run),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_last (m_last)
  );

  // run FSM, address counter and read-latency pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_addr <= '0;
      len_q    <= '0;
      fcnt     <= '0;
      rq0      <= 1'b0;
      rq1      <= 1'b0;
      rl0      <= 1'b0;
      rl1      <= 1'b0;
    end else begin
      done <= 1'b0;
      rq0  <= 1'b0;
      rq1  <= rq0;
      rl1  <= rl0;
      if (busy && take && more) begin
        ram_addr <= ram_addr + ADDR_W'(1);
        fcnt     <= fcnt + (ADDR_W+1)'(1);
        rq0      <= 1'b1;
        rl0      <= (fcnt == len_q - (ADDR_W+1)'(1));
      end
      unique case (st)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              st   <= DONE;
              done <= 1'b1;
            end else begin
              st       <= PRIME;
              busy     <= 1'b1;
              len_q    <= len;
              ram_addr <= base;
              fcnt     <= (ADDR_W+1)'(1);
              rq0      <= 1'b1;
              rl0      <= (len == (ADDR_W+1)'(1));
            end
          end
        end
        PRIME: st <= LOAD;
        LOAD:  st <= SEND;
        SEND: begin
          if (end_run) begin
            st   <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        DONE:    st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

`ifdef RAMZ_DRAIN_CKSUM_EN
  // modular sum of transferred bytes, cleared on each accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      cksum <= '0;
    end else if (st == IDLE && start) begin
      cksum <= '0;
    end else if (m_valid && m_ready) begin
      cksum <= cksum + m_data;
    end
  end
`endif
endmodule

// File: tb/tb_ramz_drain.sv
// tb_ramz_drain: directed vector table plus reset/overlap sequences.
// Behavioural 32x32 RAM with one-cycle registered read.
module tb_ramz_drain;
  import ramz_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base;
  logic [5:0]  len;
  logic        busy;
  logic        done;
  logic [4:0]  ram_addr;
  logic [31:0] ram_dout;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
`ifdef RAMZ_DRAIN_CKSUM_EN
  logic [7:0]  cksum;
`endif

  logic [31:0] mem [32];
  int ncmp = 0;
  int nbad = 0;

  typedef struct {
    logic [4:0] base;
    logic [5:0] len;
    bit         tog;
    int         poke;
    int         first_k;
    int         done_k;
  } vec_t;

  vec_t vt [6];

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[ram_addr];

  ramz_drain dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last)
`ifdef RAMZ_DRAIN_CKSUM_EN
    ,
    .cksum   (cksum)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // k counts edges after the start edge; sampling is #1 after each edge
  task automatic run(input vec_t v);
    int          first;
    int          dk;
    logic [7:0]  got [$];
    logic        lst [$];
    logic [4:0]  adr [$];
    logic        pv_stall;
    logic [7:0]  pd;
    logic        pl;
    logic [4:0]  pa;
    logic [31:0] w;
    base  = v.base;
    len   = v.len;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    first    = -1;
    dk       = -1;
    pv_stall = 1'b0;
    pd       = '0;
    pl       = 1'b0;
    adr.push_back(ram_addr);
    pa = ram_addr;
    chk("busy_after_start", busy, (v.len != 0));
    for (int k = 0; k < v.done_k + 20; k++) begin
      if (k > 0 && ram_addr !== pa) begin
        adr.push_back(ram_addr);
        pa = ram_addr;
      end
      if (pv_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, pd);
        chk("stall_last", m_last, pl);
      end
      if (m_valid && first < 0) first = k;
      if (done) begin
        dk = k;
        break;
      end
      if (k == v.poke) begin
        start = 1'b1;
        base  = v.base + 5'd9;
        len   = 6'd3;
      end else begin
        start = 1'b0;
      end
      m_ready = v.tog ? (k % 2 == 0) : 1'b1;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        lst.push_back(m_last);
      end
      pv_stall = m_valid && !m_ready;
      pd       = m_data;
      pl       = m_last;
      @(posedge clk); #1;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    chk("first_valid_k", first, v.first_k);
    chk("done_k", dk, v.done_k);
    @(posedge clk); #1;
    chk("done_width", done, 0);
    chk("busy_after_done", busy, 0);
    chk("valid_after_done", m_valid, 0);
    chk("nbytes", got.size(), 4 * v.len);
    for (int i = 0; i < got.size(); i++) begin
      w = mem[(v.base + i / 4) % 32] >> (8 * (i % 4));
      chk("byte", got[i], w[7:0]);
      chk("last_flag", lst[i], (i == 4 * v.len - 1));
    end
    if (v.len != 0) begin
      chk("naddr", adr.size(), v.len);
      for (int i = 0; i < adr.size(); i++)
        chk("addr", adr[i], (v.base + i) % 32);
    end
  endtask

  initial begin
    logic saw;
    vec_t v;
    for (int n = 0; n < 32; n++) mem[n] = n * 32'h01010101;
    mem[5] = 32'h44332211;

    vt[0] = '{5'd5,  6'd1,  1'b0, -1,  2,  6};
    vt[1] = '{5'd30, 6'd4,  1'b0, -1,  2,  18};
    vt[2] = '{5'd30, 6'd4,  1'b1, -1,  2,  33};
    vt[3] = '{5'd7,  6'd0,  1'b0, -1, -1,  0};
    vt[4] = '{5'd0,  6'd32, 1'b0, -1,  2,  130};
    vt[5] = '{5'd31, 6'd2,  1'b0,  4,  2,  10};

    rst     = 1'b1;
    start   = 1'b0;
    base    = '0;
    len     = '0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    chk("rst_addr", ram_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run(vt[i]);

    // start held through the done cycle of a len=0 run is ignored
    base  = 5'd3;
    len   = 6'd0;
    start = 1'b1;
    @(posedge clk); #1;
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("z_done_clr", done, 0);
    chk("z_busy_ignored", busy, 0);
    @(posedge clk); #1;
    chk("z_done_stay", done, 0);
    chk("z_valid_stay", m_valid, 0);

    // reset during the sixth byte of a len=8 run
    base  = 5'd3;
    len   = 6'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("r_byte6_valid", m_valid, 1);
    chk("r_byte6_data", m_data, 8'h04);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("r_busy", busy, 0);
    chk("r_valid", m_valid, 0);
    chk("r_done", done, 0);
    chk("r_data", m_data, 0);
    chk("r_addr", ram_addr, 0);
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || m_valid) saw = 1'b1;
    end
    chk("r_no_done", saw, 0);
    v = '{5'd20, 6'd2, 1'b0, -1, 2, 10};
    run(v);

`ifdef RAMZ_DRAIN_CKSUM_EN
    mem[8] = 32'h01020304;
    mem[9] = 32'h000000FF;
    v = '{5'd8, 6'd2, 1'b0, 3, 2, 10};
    run(v);
    chk("cksum", cksum, 8'h09);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
